// File: rtl/igpu_decomp.sv
// igpu_decomp: rebuilds a 16-pixel RGBA tile from one compressed line (empty/raw/delta/solid) and streams it one pixel per beat.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_lines/in_flag line input;
// out_valid/out_ready/out_pixel/out_index/out_last pixel stream; err_count malformed-line count.
// Optional macro IGPU_DECOMP_ERR_EN builds the saturating malformed-line counter; otherwise err_count is 0.
module igpu_decomp #(
  parameter int RES_W     = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [511:0]         in_lines,
  input  logic [1:0]           in_flag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pixel,
  output logic [3:0]           out_index,
  output logic                 out_last,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t       state_q, state_d;
  logic [511:0] line_q, line_d, res_sh;
  logic [1:0]   flag_q, flag_d;
  logic [3:0]   idx_q, idx_d;
  logic [31:0]  acc_q, acc_d, acc_nx;
  logic         accept, adv;
  assign out_valid = state_q == EMIT;
  assign in_ready  = state_q == IDLE || (out_ready && idx_q == 4'd15);
  assign accept    = in_valid && in_ready;
  assign adv       = out_valid && out_ready;
  assign out_index = idx_q;
  assign out_last  = out_valid && idx_q == 4'd15;
  assign out_pixel = !out_valid ? '0 :
                     flag_q == 2'b01 ? line_q[32*idx_q +: 32] :
                     flag_q == 2'b11 ? line_q[31:0] : acc_q;
  // residuals for pixel idx_q+1 land at the bottom of res_sh
  assign res_sh = line_q >> (32 + 32'(idx_q) * 4 * RES_W);
  always_comb begin
    acc_nx = acc_q;
    for (int c = 0; c < 4; c++)
      acc_nx[8*c +: 8] = acc_q[8*c +: 8] + 8'($signed(res_sh[c*RES_W +: RES_W]));
  end
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    flag_d  = flag_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (accept) begin
      state_d = in_flag == 2'b00 ? IDLE : EMIT;
      line_d  = in_lines;
      flag_d  = in_flag;
      idx_d   = '0;
      acc_d   = in_lines[31:0];
    end else if (adv) begin
      state_d = idx_q == 4'd15 ? IDLE : EMIT;
      idx_d   = idx_q + 4'd1;
      acc_d   = acc_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      flag_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      flag_q  <= flag_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end
`ifdef IGPU_DECOMP_ERR_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 bad;
  assign bad = (in_flag == 2'b10 && |(in_lines >> (32 + 60 * RES_W))) ||
               (in_flag == 2'b11 && |in_lines[511:32]);
  assign err_d = (accept && bad && !(&err_q)) ? err_q + ERR_CNT_W'(1) : err_q;
  always_ff @(posedge clk) begin
    err_q <= rst ? '0 : err_d;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_igpu_decomp.sv
module tb_igpu_decomp;
  localparam int RES_W = 4;
  localparam int ERR_CNT_W = 16;
  typedef struct packed {logic [31:0] px; logic [3:0] idx;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_last, stall_en = 0;
  logic [511:0] in_lines = '0, line;
  logic [1:0] in_flag = '0;
  logic [31:0] out_pixel;
  logic [3:0] out_index;
  logic [ERR_CNT_W-1:0] err_count;
  exp_t sb[$];
  int pass_cnt = 0, tot_cnt = 0;

  igpu_decomp #(.RES_W(RES_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_lines(in_lines),
    .in_flag(in_flag), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_index(out_index), .out_last(out_last), .err_count(err_count));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] px, input logic [3:0] idx);
    exp_t e;
    e.px = px;
    e.idx = idx;
    sb.push_back(e);
  endtask

  // scoreboard monitor: every presented beat (stalled or not) must match the head entry
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) check("unexpected_beat", {28'd0, out_index, out_pixel}, 64'hDEAD);
      else begin
        check("pixel", out_pixel, sb[0].px);
        check("index", out_index, sb[0].idx);
        check("last", out_last, sb[0].idx == 4'd15);
        check("in_ready_emit", in_ready, out_ready && sb[0].idx == 4'd15);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // consumer: when enabled, refuse beats 3 and 7 for one cycle each
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (stall_en && out_ready && out_valid && (out_index == 4'd3 || out_index == 4'd7)) ? 1'b0 : 1'b1;
    end
  end

  task automatic send(input logic [1:0] f, input logic [511:0] l);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid = 1;
    in_flag = f;
    in_lines = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n >= 200, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    check("first_valid", out_valid, f != 2'b00);
    if (f != 2'b00) check("first_index", out_index, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", n >= 500, 0);
  endtask

  task automatic raw_tile(input logic [31:0] base);
    for (int k = 0; k < 16; k++) begin
      line[32*k +: 32] = base + 32'(k);
      push(base + 32'(k), 4'(k));
    end
    send(2'b01, line);
  endtask

  task automatic delta_tile(input logic [3:0] r, input logic top);
    logic [7:0] b0, b1, b2, b3;
    for (int k = 0; k < 16; k++) begin
      b3 = (r == 4'h1) ? 8'hFF + 8'(k) : 8'hFF - 8'(k);
      b2 = (r == 4'h1) ? 8'h10 + 8'(k) : 8'h10 - 8'(k);
      b1 = (r == 4'h1) ? 8'h20 + 8'(k) : 8'h20 - 8'(k);
      b0 = (r == 4'h1) ? 8'h30 + 8'(k) : 8'h30 - 8'(k);
      push({b3, b2, b1, b0}, 4'(k));
    end
    line = {272'd0, {60{r}}, 32'hFF102030};
    line[511] = top;
    send(2'b10, line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_count", err_count, 0);
    rst = 0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    // raw: word k = k
    raw_tile(32'd0);
    drain();
    // solid
    line = '0;
    line[31:0] = 32'hDEADBEEF;
    for (int k = 0; k < 16; k++) push(32'hDEADBEEF, 4'(k));
    send(2'b11, line);
    drain();
    // delta +1 and -1, spot values hand-checked: p1=00112131, p15=0E1F2F3F, p1(-1)=FE0F1F2F
    check("hand_p1", {8'hFF + 8'd1, 8'h11, 8'h21, 8'h31}, 32'h00112131);
    delta_tile(4'h1, 1'b0);
    drain();
    delta_tile(4'hF, 1'b0);
    drain();
    // backpressure and back-to-back raw tiles
    stall_en = 1;
    raw_tile(32'hA0000000);
    raw_tile(32'hB0000000);
    drain();
    stall_en = 0;
    // empty line
    send(2'b00, {16{32'h12345678}});
    check("empty_in_ready", in_ready, 1);
    check("empty_sb", sb.size(), 0);
    // reset at index 5
    raw_tile(32'hC0000000);
    n = 0;
    while (!(out_valid && out_index == 4'd5) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idx5_timeout", n >= 50, 0);
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_last", out_last, 0);
    rst = 0;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_no_beat", out_valid, 0);
`ifdef IGPU_DECOMP_ERR_EN
    delta_tile(4'h1, 1'b1);
    drain();
    line = '0;
    line[31:0] = 32'h01020304;
    line[40] = 1'b1;
    for (int k = 0; k < 16; k++) push(32'h01020304, 4'(k));
    send(2'b11, line);
    drain();
    check("err_count", err_count, 2);
`else
    delta_tile(4'h1, 1'b1);
    drain();
    check("err_count_off", err_count, 0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
